memory_bus_arbiter: RTL and testbench
=====================================

// Module: memory_bus_arbiter
// PURPOSE
// - Multiplexes N mem_bus controllers (DMA engines, CPU bridge, ...) onto one memory device port (SDRAM/flash ctrl).
// - Sits directly downstream of each DMA engine's mem_bus controller port; device side keeps the same request/ack protocol.
// - Round-robin, one transfer per grant; never interleaves or drops a transfer.
// PARAMETERS
// - NUM_CONTROLLERS  3   number of controller ports, 2..8
// - ADDR_WIDTH       27  byte address width
// - DATA_WIDTH       16  data width; wmask is DATA_WIDTH/8 bits
// PORTS
// - clk              in   1                  clock
// - reset            in   1                  synchronous, active-high reset
// - c_request        in   N                  per-controller request, held until ack
// - c_write          in   N                  per-controller direction, 1 = write
// - c_address        in   N*ADDR_WIDTH       per-controller address, packed, ctrl 0 in LSBs
// - c_wdata          in   N*DATA_WIDTH       per-controller write data
// - c_wmask          in   N*DATA_WIDTH/8     per-controller byte mask
// - c_ack            out  N                  one-cycle ack to the granted controller only
// - c_rdata          out  DATA_WIDTH         read data, broadcast, valid in c_ack cycle
// - d_request        out  1                  device request
// - d_write          out  1                  device direction
// - d_address        out  ADDR_WIDTH         device address
// - d_wdata          out  DATA_WIDTH         device write data
// - d_wmask          out  DATA_WIDTH/8       device byte mask
// - d_ack            in   1                  device one-cycle ack
// - d_rdata          in   DATA_WIDTH         device read data, valid with d_ack
// - grant_id         out  $clog2(N)          index of current/last grant (debug)
// BEHAVIOUR
// - Reset: d_request=0, d_write/d_address/d_wdata/d_wmask=0, c_ack=0, grant_id=0, rr pointer=0, state=IDLE.
// - FSM IDLE: if any c_request, pick first set bit at or after rr pointer, wrapping (N-1 -> 0).
//   Register winner into grant_id; latch its write/address/wdata/wmask into d_* and set d_request=1; go BUSY.
//   Latency: c_request high in cycle T -> d_request high in T+1.
// - FSM BUSY: d_* held stable; other requests ignored.
//   On d_ack: c_ack[grant_id]=1 combinationally in the same cycle, c_rdata=d_rdata, d_request<=0,
//   rr pointer<=grant_id+1 (wrap to 0 past N-1), go IDLE.
// - c_rdata = d_rdata at all times; controllers sample it only with their c_ack bit.
// - Back-to-back: a controller re-asserts c_request after ack; earliest re-grant is the cycle after IDLE is re-entered.
//   Minimum spacing of device requests is 1 idle cycle.
// - A controller drops request in the cycle after its ack (registered); IDLE samples one cycle after ack,
//   so a stale request is never re-granted.
// - Fairness: with all N requesting continuously, grants cycle 0,1,..,N-1,0 with no repeats.
// - d_ack in IDLE: ignored, no c_ack.
// - c_request dropped by granted controller while BUSY (protocol violation): transfer still completes,
//   ack still pulsed.
// - Reset while BUSY: all outputs to reset values next edge; the outstanding transfer is abandoned.
//   The device is reset by the same signal.
// - Unused c_request bits (N not power of 2): grant_id never exceeds N-1.
// STRUCTURE
// - memory_pkg: mem_arb_state_e {IDLE, BUSY}; localparam MEM_ADDR_WIDTH=27, MEM_DATA_WIDTH=16.
// - Sub-module memory_rr_picker (combinational): inputs request[N], pointer;
//   outputs valid, index (first set bit from pointer, wrapping).
// - Top holds FSM, rr pointer, grant_id, d_* registers, ack demux.
// TESTING
// - Single ctrl 1 write addr 0x0000100 data 0xA55A mask 2'b11, d_ack 3 cycles later
//   -> d_request at T+1 with those values, c_ack=3'b010 exactly once.
// - Ctrls 0,1,2 request continuously, 9 transfers -> grant order 0,1,2,0,1,2,0,1,2; d_* never change while d_request=1.
// - Ctrl 2 read 0x4000000, d_rdata=0x1234 with d_ack -> c_ack=3'b100, c_rdata=0x1234 same cycle, d_request=0 next cycle.
// - Pointer wrap: last grant 2, then ctrls 0 and 1 request -> ctrl 0 granted first.
// - Spurious d_ack in IDLE -> c_ack stays 0, state stays IDLE.
// - reset asserted 1 cycle after grant (BUSY) -> next cycle d_request=0, grant_id=0; next request from ctrl 1 is served.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared types and default widths for the memory bus arbiter slice.
package memory_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 27;
  localparam int unsigned MEM_DATA_WIDTH = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_arb_state_e;

  // Successor of a controller index, wrapping past n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/memory_rr_picker.sv
// Combinational round-robin picker: first set request bit at or after pointer, wrapping.
module memory_rr_picker #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] pointer,
  output logic          valid,
  output logic [IW-1:0] index
);

  int unsigned cand;

  // Scan from the farthest offset down so the nearest match is written last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 0;
    for (int unsigned k = N; k > 0; k--) begin
      cand = (32'(pointer) + k - 1) % N;
      if (request[IW'(cand)]) begin
        valid = 1'b1;
        index = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter multiplexing N mem_bus controllers onto one memory device port,
// one complete request/ack transfer per grant.
module memory_bus_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned NUM_CONTROLLERS = 3,
  parameter int unsigned ADDR_WIDTH      = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = MEM_DATA_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CONTROLLERS-1:0]             c_request,
  input  logic [NUM_CONTROLLERS-1:0]             c_write,
  input  logic [NUM_CONTROLLERS*ADDR_WIDTH-1:0]  c_address,
  input  logic [NUM_CONTROLLERS*DATA_WIDTH-1:0]  c_wdata,
  input  logic [NUM_CONTROLLERS*(DATA_WIDTH/8)-1:0] c_wmask,
  output logic [NUM_CONTROLLERS-1:0]             c_ack,
  output logic [DATA_WIDTH-1:0]                  c_rdata,
  output logic                                   d_request,
  output logic                                   d_write,
  output logic [ADDR_WIDTH-1:0]                  d_address,
  output logic [DATA_WIDTH-1:0]                  d_wdata,
  output logic [DATA_WIDTH/8-1:0]                d_wmask,
  input  logic                                   d_ack,
  input  logic [DATA_WIDTH-1:0]                  d_rdata,
  output logic [$clog2(NUM_CONTROLLERS)-1:0]     grant_id
);

  localparam int unsigned N  = NUM_CONTROLLERS;
  localparam int unsigned MW = DATA_WIDTH / 8;
  localparam int unsigned IW = $clog2(NUM_CONTROLLERS);

  mem_arb_state_e  state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_d;
  logic            d_request_d;
  logic            d_write_d;
  logic [ADDR_WIDTH-1:0] d_address_d;
  logic [DATA_WIDTH-1:0] d_wdata_d;
  logic [MW-1:0]   d_wmask_d;
  logic            pick_valid;
  logic [IW-1:0]   pick_index;

  memory_rr_picker #(
    .N  (N),
    .IW (IW)
  ) u_picker (
    .request (c_request),
    .pointer (rr_ptr_q),
    .valid   (pick_valid),
    .index   (pick_index)
  );

  // Next-state logic: IDLE latches the winner's command, BUSY waits for the device ack.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_id;
    d_request_d = d_request;
    d_write_d   = d_write;
    d_address_d = d_address;
    d_wdata_d   = d_wdata;
    d_wmask_d   = d_wmask;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d     = BUSY;
          grant_d     = pick_index;
          d_request_d = 1'b1;
          for (int unsigned i = 0; i < N; i++) begin
            if (pick_index == IW'(i)) begin
              d_write_d   = c_write[i];
              d_address_d = c_address[i*ADDR_WIDTH +: ADDR_WIDTH];
              d_wdata_d   = c_wdata[i*DATA_WIDTH +: DATA_WIDTH];
              d_wmask_d   = c_wmask[i*MW +: MW];
            end
          end
        end
      end
      BUSY: begin
        if (d_ack) begin
          state_d     = IDLE;
          d_request_d = 1'b0;
          rr_ptr_d    = IW'(rr_next(32'(grant_id), N));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_id  <= '0;
      d_request <= 1'b0;
      d_write   <= 1'b0;
      d_address <= '0;
      d_wdata   <= '0;
      d_wmask   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_id  <= grant_d;
      d_request <= d_request_d;
      d_write   <= d_write_d;
      d_address <= d_address_d;
      d_wdata   <= d_wdata_d;
      d_wmask   <= d_wmask_d;
    end
  end

  // Ack is steered combinationally so the controller sees it in the device-ack cycle.
  always_comb begin
    c_ack = '0;
    if (state_q == BUSY && d_ack) c_ack[grant_id] = 1'b1;
  end

  assign c_rdata = d_rdata;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Randomized self-checking bench for memory_bus_arbiter against a transaction-level model.
module tb_memory_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 27;
  localparam int DW = 16;
  localparam int MW = DW / 8;
  localparam int IW = $clog2(N);

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      c_request;
  logic [N-1:0]      c_write;
  logic [N*AW-1:0]   c_address;
  logic [N*DW-1:0]   c_wdata;
  logic [N*MW-1:0]   c_wmask;
  logic [N-1:0]      c_ack;
  logic [DW-1:0]     c_rdata;
  logic              d_request;
  logic              d_write;
  logic [AW-1:0]     d_address;
  logic [DW-1:0]     d_wdata;
  logic [MW-1:0]     d_wmask;
  logic              d_ack;
  logic [DW-1:0]     d_rdata;
  logic [IW-1:0]     grant_id;

  always #5 clk = ~clk;

  memory_bus_arbiter #(
    .NUM_CONTROLLERS (N),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .c_request (c_request),
    .c_write   (c_write),
    .c_address (c_address),
    .c_wdata   (c_wdata),
    .c_wmask   (c_wmask),
    .c_ack     (c_ack),
    .c_rdata   (c_rdata),
    .d_request (d_request),
    .d_write   (d_write),
    .d_address (d_address),
    .d_wdata   (d_wdata),
    .d_wmask   (d_wmask),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .grant_id  (grant_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Controller-side transaction state
  bit            pend [N];
  int            cool [N];
  logic          t_write [N];
  logic [AW-1:0] t_addr [N];
  logic [DW-1:0] t_wdata [N];
  logic [MW-1:0] t_mask [N];
  int            ack_cnt [N];
  int            grant_log [$];
  logic [N-1:0]  last_ack;
  logic [DW-1:0] last_rdata;

  // Device-side model
  bit dev_armed;
  int dev_dly;

  // Reference model of the arbiter as seen from its ports
  bit            m_busy;
  int            m_ptr;
  int            m_gid;
  logic          m_dreq;
  logic          m_dw;
  logic [AW-1:0] m_da;
  logic [DW-1:0] m_dwd;
  logic [MW-1:0] m_dm;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic new_txn(input int i);
    pend[i]    = 1'b1;
    t_write[i] = 1'($urandom);
    t_addr[i]  = AW'($urandom);
    t_wdata[i] = DW'($urandom);
    t_mask[i]  = MW'($urandom);
  endtask

  task automatic drive_ctrls();
    for (int i = 0; i < N; i++) begin
      c_request[i]           = pend[i];
      c_write[i]             = t_write[i];
      c_address[i*AW +: AW]  = t_addr[i];
      c_wdata[i*DW +: DW]    = t_wdata[i];
      c_wmask[i*MW +: MW]    = t_mask[i];
    end
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    logic [N-1:0] exp_ack;
    bit           granted;
    #1;
    exp_ack = '0;
    if (m_busy && d_ack) exp_ack[m_gid] = 1'b1;
    check_eq("c_ack", 64'(c_ack), 64'(exp_ack));
    check_eq("c_rdata", 64'(c_rdata), 64'(d_rdata));
    last_ack   = c_ack;
    last_rdata = c_rdata;
    for (int i = 0; i < N; i++) begin
      if (c_ack[i]) begin
        ack_cnt[i]++;
        grant_log.push_back(i);
      end
    end
    if (reset) begin
      m_busy = 1'b0; m_ptr = 0; m_gid = 0; m_dreq = 1'b0;
      m_dw = 1'b0; m_da = '0; m_dwd = '0; m_dm = '0;
    end else if (!m_busy) begin
      granted = 1'b0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (c_request[j] && !granted) begin
          granted = 1'b1;
          m_busy  = 1'b1;
          m_gid   = j;
          m_dreq  = 1'b1;
          m_dw    = c_write[j];
          m_da    = c_address[j*AW +: AW];
          m_dwd   = c_wdata[j*DW +: DW];
          m_dm    = c_wmask[j*MW +: MW];
        end
      end
    end else if (d_ack) begin
      m_busy = 1'b0;
      m_dreq = 1'b0;
      m_ptr  = (m_gid + 1) % N;
    end
    @(posedge clk);
    #1;
    check_eq("d_request", 64'(d_request), 64'(m_dreq));
    check_eq("grant_id", 64'(grant_id), 64'(m_gid));
    check_eq("d_write", 64'(d_write), 64'(m_dw));
    check_eq("d_address", 64'(d_address), 64'(m_da));
    check_eq("d_wdata", 64'(d_wdata), 64'(m_dwd));
    check_eq("d_wmask", 64'(d_wmask), 64'(m_dm));
    for (int i = 0; i < N; i++) begin
      if (last_ack[i]) begin
        pend[i] = 1'b0;
        cool[i] = 1;
      end
    end
  endtask

  task automatic cycle_man(input logic ack, input logic [DW-1:0] rd);
    drive_ctrls();
    d_ack   = ack;
    d_rdata = rd;
    step();
  endtask

  task automatic cycle_auto(input bit allow_new, input int pct, input bit spurious);
    for (int i = 0; i < N; i++) begin
      if (cool[i] > 0) cool[i]--;
      else if (!pend[i] && allow_new && $urandom_range(0, 99) < pct) new_txn(i);
    end
    drive_ctrls();
    d_rdata = DW'($urandom);
    d_ack   = 1'b0;
    if (d_request) begin
      if (!dev_armed) begin
        dev_armed = 1'b1;
        dev_dly   = $urandom_range(0, 3);
      end
      if (dev_dly == 0) begin
        d_ack     = 1'b1;
        dev_armed = 1'b0;
      end else begin
        dev_dly--;
      end
    end else if (spurious && $urandom_range(0, 7) == 0) begin
      d_ack = 1'b1;
    end
    step();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      cool[i] = 0;
    end
    dev_armed = 1'b0;
    for (int c = 0; c < cycles; c++) cycle_man(1'b0, DW'($urandom));
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit busy_any;
    busy_any = 1'b1;
    for (int k = 0; k < 300 && busy_any; k++) begin
      cycle_auto(1'b0, 0, 1'b0);
      busy_any = d_request;
      for (int i = 0; i < N; i++) if (pend[i]) busy_any = 1'b1;
    end
    check_eq(tag, 64'(busy_any), 64'd0);
  endtask

  initial begin
    int a0;
    bit seen;
    c_request = '0; c_write = '0; c_address = '0; c_wdata = '0; c_wmask = '0;
    d_ack = 1'b0; d_rdata = '0; reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; cool[i] = 0; ack_cnt[i] = 0;
      t_write[i] = 1'b0; t_addr[i] = '0; t_wdata[i] = '0; t_mask[i] = '0;
    end
    m_busy = 1'b0; m_ptr = 0; m_gid = 0; m_dreq = 1'b0;
    m_dw = 1'b0; m_da = '0; m_dwd = '0; m_dm = '0;
    dev_armed = 1'b0; dev_dly = 0;

    // Reset state
    do_reset(2);
    check_eq("rst_d_request", 64'(d_request), 64'd0);
    check_eq("rst_grant_id", 64'(grant_id), 64'd0);

    // Single write from controller 1, device ack on the third busy cycle
    pend[1] = 1'b1; t_write[1] = 1'b1; t_addr[1] = 27'h0000100;
    t_wdata[1] = 16'hA55A; t_mask[1] = 2'b11;
    a0 = ack_cnt[1];
    cycle_man(1'b0, 16'h0);
    check_eq("t1_dreq", 64'(d_request), 64'd1);
    check_eq("t1_gid", 64'(grant_id), 64'd1);
    check_eq("t1_addr", 64'(d_address), 64'h100);
    check_eq("t1_wdata", 64'(d_wdata), 64'hA55A);
    check_eq("t1_wmask", 64'(d_wmask), 64'h3);
    check_eq("t1_write", 64'(d_write), 64'd1);
    cycle_man(1'b0, 16'h0);
    cycle_man(1'b0, 16'h0);
    cycle_man(1'b1, 16'h0);
    check_eq("t1_ack", 64'(last_ack), 64'h2);
    for (int c = 0; c < 3; c++) cycle_man(1'b0, 16'h0);
    check_eq("t1_ack_once", 64'(ack_cnt[1] - a0), 64'd1);

    // Fairness: all controllers requesting continuously
    do_reset(1);
    grant_log.delete();
    for (int i = 0; i < N; i++) new_txn(i);
    for (int k = 0; k < 300 && grant_log.size() < 9; k++) cycle_auto(1'b1, 100, 1'b0);
    check_eq("t2_grants", 64'(grant_log.size() >= 9), 64'd1);
    for (int k = 0; k < 9 && k < grant_log.size(); k++)
      check_eq($sformatf("t2_order_%0d", k), 64'(grant_log[k]), 64'(k % N));
    drain("t2_drain");

    // Controller 2 read with returned data
    pend[2] = 1'b1; t_write[2] = 1'b0; t_addr[2] = 27'h4000000;
    t_wdata[2] = 16'h0; t_mask[2] = 2'b00;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cycle_man(1'b0, 16'h0);
      seen = d_request;
    end
    check_eq("t3_dreq", 64'(seen), 64'd1);
    check_eq("t3_addr", 64'(d_address), 64'h4000000);
    cycle_man(1'b1, 16'h1234);
    check_eq("t3_ack", 64'(last_ack), 64'h4);
    check_eq("t3_rdata", 64'(last_rdata), 64'h1234);
    check_eq("t3_dreq_low", 64'(d_request), 64'd0);

    // Pointer wrap after a grant to the last controller
    cycle_man(1'b0, 16'h0);
    new_txn(0);
    new_txn(1);
    cycle_man(1'b0, 16'h0);
    check_eq("t4_first", 64'(grant_id), 64'd0);
    drain("t4_drain");
    check_eq("t4_last", 64'(grant_id), 64'd1);

    // Spurious device ack while idle
    cycle_man(1'b1, 16'hBEEF);
    check_eq("t5_no_ack", 64'(last_ack), 64'd0);
    check_eq("t5_idle", 64'(d_request), 64'd0);
    new_txn(2);
    cycle_man(1'b0, 16'h0);
    check_eq("t5_grant_after", 64'(d_request), 64'd1);
    drain("t5_drain");

    // Reset while busy abandons the transfer
    new_txn(0);
    cycle_man(1'b0, 16'h0);
    check_eq("t6_busy", 64'(d_request), 64'd1);
    do_reset(1);
    check_eq("t6_rst_dreq", 64'(d_request), 64'd0);
    check_eq("t6_rst_gid", 64'(grant_id), 64'd0);
    a0 = ack_cnt[1];
    new_txn(1);
    drain("t6_drain");
    check_eq("t6_served", 64'(ack_cnt[1] - a0), 64'd1);

    // Randomized traffic with random device latency and spurious acks
    for (int k = 0; k < 800; k++) cycle_auto(1'b1, 30, 1'b1);
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
